laser_rx_deframer: RTL

Receive-side deframer for the laser link: oversamples the photodiode input on the system clock, recovers start/data/stop framing, and emits one byte per valid frame as a single-cycle `data_valid` pulse. It is the receive partner of the laser transmit path. Its byte output feeds the FTDI write queue in loopback/bridge top levels. It also reports framing errors and keeps a received-byte count for the hex display.

---
 rtl/laser_rx_deframer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/laser_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : laser_rx_deframer
// Purpose  : Receive-side deframer for the laser link. Oversamples the raw
//            photodiode level on the system clock, recovers start / data /
//            stop framing (idle 0, start 1, DATA_BITS LSB first, stop 0) and
//            emits one byte per good frame as a single-cycle data_valid pulse.
//            Reports stop-bit framing errors and keeps a good-frame count.
// Ports    : clock      - system clock, rising edge
//            reset      - asynchronous, active-low
//            en         - receiver enable; low forces idle
//            laser_in   - raw asynchronous photodiode level
//            data_valid - one-cycle pulse when a good frame completes
//            data_in    - last good byte (updates only with data_valid)
//            frame_err  - one-cycle pulse when the stop bit samples high
//            busy       - high whenever the FSM is not idle
//            rx_count   - good frames received, wraps at 16 bits
// Params   : CLKS_PER_BIT >= 3, DATA_BITS >= 2
// Revision : 1.0 - initial release
// ============================================================================
module laser_rx_deframer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 laser_in,
  output logic                 data_valid,
  output logic [DATA_BITS-1:0] data_in,
  output logic                 frame_err,
  output logic                 busy,
  output logic [15:0]          rx_count
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] C_HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] C_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] C_IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t               state, state_n;
  logic                 sync_meta, sync;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 dv_n, fe_n;

  // Two-flop synchronizer; only the second stage is ever looked at.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= laser_in;
      sync      <= sync_meta;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      data_in    <= '0;
      rx_count   <= 16'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      data_valid <= dv_n;
      frame_err  <= fe_n;
      if (dv_n) begin
        data_in  <= shreg;
        rx_count <= rx_count + 16'd1;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    dv_n    = 1'b0;
    fe_n    = 1'b0;
    if (!en) begin
      // Disabling abandons any partial frame without reporting it.
      state_n = S_IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sync) begin
            state_n = S_START;
            cnt_n   = '0;
          end
        end
        S_START: begin
          // Re-check the start bit near its middle; a short glitch falls back
          // to idle without any error indication.
          if (cnt == C_HALF_M1) begin
            cnt_n = '0;
            if (sync) begin
              state_n = S_DATA;
              idx_n   = '0;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == C_LAST) begin
            cnt_n = '0;
            // Right shift: after DATA_BITS samples the first (LSB) bit sits
            // at bit 0.
            shreg_n = {sync, shreg[DATA_BITS-1:1]};
            idx_n   = idx + IW'(1);
            if (idx == C_IDX_LAST) begin
              state_n = S_STOP;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt == C_LAST) begin
            cnt_n = '0;
            if (!sync) begin
              dv_n    = 1'b1;
              state_n = S_IDLE;
            end else begin
              fe_n    = 1'b1;
              state_n = S_BREAK;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_BREAK: begin
          // Wait out a stuck-high line so it is not mistaken for a new start.
          if (!sync) begin
            state_n = S_IDLE;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule
`default_nettype wire
